sync_ram_arbiter: RTL and testbench

//  Two-requester round-robin arbiter and sequencer for the single-port synchronous RAM (16x8 default).

---
 rtl/sync_ram_arbiter.sv | 134 +++++++++++++
 tb/tb_sync_ram_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/sync_ram_arbiter.sv
// Two-requester round-robin arbiter/sequencer for a single-port synchronous RAM.
// Optionally zero-fills the RAM after reset before any grant is issued.
module sync_ram_arbiter #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned ADDR_W     = 4,
    parameter bit          INIT_CLEAR = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              init_done,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam state_t RST_STATE = INIT_CLEAR ? ST_INIT : ST_RUN;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] clr_addr, clr_addr_nxt;
    logic              prio, prio_nxt;
    logic [ADDR_W-1:0] last_addr;
    logic [DATA_W-1:0] last_din;
    logic              gnt0_int, gnt1_int, we_int;
    logic [ADDR_W-1:0] addr_int;
    logic [DATA_W-1:0] din_int;
    logic              clr_last;

    assign clr_last = (state == ST_INIT) && (clr_addr == LAST_ADDR);

    // Next-state, arbitration and RAM drive.
    always_comb begin
        state_nxt    = state;
        clr_addr_nxt = clr_addr;
        prio_nxt     = prio;
        gnt0_int     = 1'b0;
        gnt1_int     = 1'b0;
        we_int       = 1'b0;
        addr_int     = last_addr;
        din_int      = last_din;
        case (state)
            ST_INIT: begin
                we_int       = 1'b1;
                addr_int     = clr_addr;
                din_int      = '0;
                clr_addr_nxt = ADDR_W'(clr_addr + 1'b1);
                if (clr_addr == LAST_ADDR) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (req0 && req1) begin
                    gnt0_int = ~prio;
                    gnt1_int = prio;
                    prio_nxt = ~prio;
                end else begin
                    gnt0_int = req0;
                    gnt1_int = req1;
                end
                if (gnt0_int) begin
                    we_int   = we0;
                    addr_int = addr0;
                    din_int  = wdata0;
                end else if (gnt1_int) begin
                    we_int   = we1;
                    addr_int = addr1;
                    din_int  = wdata1;
                end
            end
        endcase
    end

    // Strobes are suppressed while reset is held, independent of state.
    assign gnt0     = gnt0_int & rst_n;
    assign gnt1     = gnt1_int & rst_n;
    assign ram_we   = we_int & rst_n;
    assign ram_addr = addr_int;
    assign ram_din  = din_int;
    assign rdata    = ram_dout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RST_STATE;
            clr_addr <= '0;
            prio     <= 1'b0;
        end else begin
            state    <= state_nxt;
            clr_addr <= clr_addr_nxt;
            prio     <= prio_nxt;
        end
    end

    // Last granted address/data, held on idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_addr <= '0;
            last_din  <= '0;
        end else if (gnt0_int || gnt1_int) begin
            last_addr <= addr_int;
            last_din  <= din_int;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            init_done <= ~INIT_CLEAR;
        end else begin
            rvalid0 <= gnt0_int & ~we0;
            rvalid1 <= gnt1_int & ~we1;
            if (clr_last) begin
                init_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sync_ram_arbiter.sv
// Directed bench for sync_ram_arbiter with a behavioural registered-output RAM.
module tb_sync_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1, we0, we1;
    logic [3:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1, init_done, ram_we;
    logic [7:0] rdata, ram_din, ram_dout;
    logic [3:0] ram_addr;
    logic [7:0] mem [16];

    int ntests = 0;
    int nfail  = 0;

    sync_ram_arbiter #(.DATA_W(8), .ADDR_W(4), .INIT_CLEAR(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .init_done(init_done),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    typedef struct {
        logic       r0, w0; logic [3:0] a0; logic [7:0] d0;
        logic       r1, w1; logic [3:0] a1; logic [7:0] d1;
        logic       g0, g1, v0, v1, we; logic [3:0] addr; logic [7:0] din; logic [7:0] rd;
    } vec_t;

    vec_t vecs [14];

    function automatic vec_t mk(input logic r0, w0, input logic [3:0] a0, input logic [7:0] d0,
                                input logic r1, w1, input logic [3:0] a1, input logic [7:0] d1,
                                input logic g0, g1, v0, v1, we, input logic [3:0] addr,
                                input logic [7:0] din, rd);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1; v.we = we;
        v.addr = addr; v.din = din; v.rd = rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    endtask

    initial begin
        // r0 w0 a0 d0 | r1 w1 a1 d1 | g0 g1 v0 v1 we addr din rd
        vecs[0]  = mk(1,1,3,8'hAA, 0,0,0,8'h00, 1,0,0,0,1, 3,8'hAA,8'h00);
        vecs[1]  = mk(1,0,3,8'h00, 0,0,0,8'h00, 1,0,0,0,0, 3,8'h00,8'h00);
        vecs[2]  = mk(0,0,0,8'h00, 0,0,0,8'h00, 0,0,1,0,0, 3,8'h00,8'hAA);
        vecs[3]  = mk(0,0,0,8'h00, 1,1,2,8'h22, 0,1,0,0,1, 2,8'h22,8'h00);
        vecs[4]  = mk(1,1,1,8'h11, 0,0,0,8'h00, 1,0,0,0,1, 1,8'h11,8'h00);
        vecs[5]  = mk(1,0,1,8'h00, 1,0,2,8'h00, 1,0,0,0,0, 1,8'h00,8'h00);
        vecs[6]  = mk(1,0,1,8'h00, 1,0,2,8'h00, 0,1,1,0,0, 2,8'h00,8'h11);
        vecs[7]  = mk(1,0,1,8'h00, 1,0,2,8'h00, 1,0,0,1,0, 1,8'h00,8'h22);
        vecs[8]  = mk(1,0,1,8'h00, 1,0,2,8'h00, 0,1,1,0,0, 2,8'h00,8'h11);
        vecs[9]  = mk(0,0,0,8'h00, 0,0,0,8'h00, 0,0,0,1,0, 2,8'h00,8'h22);
        vecs[10] = mk(1,0,5,8'h00, 1,1,5,8'h55, 1,0,0,0,0, 5,8'h00,8'h00);
        vecs[11] = mk(1,0,5,8'h00, 1,1,5,8'h55, 0,1,1,0,1, 5,8'h55,8'h00);
        vecs[12] = mk(1,0,5,8'h00, 0,0,0,8'h00, 1,0,0,0,0, 5,8'h00,8'h00);
        vecs[13] = mk(0,0,0,8'h00, 0,0,0,8'h00, 0,0,1,0,0, 5,8'h00,8'h55);

        // Reset with a write request already pending; it must wait out the clear.
        rst_n = 1'b0;
        idle();
        req0 = 1; we0 = 1; addr0 = 4'd7; wdata0 = 8'h77;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt0", 32'(gnt0), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_rvalid0", 32'(rvalid0), 32'd0);
        chk("rst_rvalid1", 32'(rvalid1), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 16; i++) begin
            chk("init_we", 32'(ram_we), 32'd1);
            chk("init_addr", 32'(ram_addr), 32'(i));
            chk("init_din", 32'(ram_din), 32'd0);
            chk("init_gnt0", 32'(gnt0), 32'd0);
            chk("init_done_low", 32'(init_done), 32'd0);
            @(posedge clk);
            #1;
        end
        chk("init_done_high", 32'(init_done), 32'd1);
        chk("held_req_gnt0", 32'(gnt0), 32'd1);
        chk("held_req_we", 32'(ram_we), 32'd1);
        chk("held_req_addr", 32'(ram_addr), 32'd7);
        chk("held_req_din", 32'(ram_din), 32'h77);

        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            #1;
            req0 = vecs[i].r0; we0 = vecs[i].w0; addr0 = vecs[i].a0; wdata0 = vecs[i].d0;
            req1 = vecs[i].r1; we1 = vecs[i].w1; addr1 = vecs[i].a1; wdata1 = vecs[i].d1;
            #3;
            chk($sformatf("v%0d_gnt0", i), 32'(gnt0), 32'(vecs[i].g0));
            chk($sformatf("v%0d_gnt1", i), 32'(gnt1), 32'(vecs[i].g1));
            chk($sformatf("v%0d_rvalid0", i), 32'(rvalid0), 32'(vecs[i].v0));
            chk($sformatf("v%0d_rvalid1", i), 32'(rvalid1), 32'(vecs[i].v1));
            chk($sformatf("v%0d_ram_we", i), 32'(ram_we), 32'(vecs[i].we));
            chk($sformatf("v%0d_ram_addr", i), 32'(ram_addr), 32'(vecs[i].addr));
            if (vecs[i].we) chk($sformatf("v%0d_ram_din", i), 32'(ram_din), 32'(vecs[i].din));
            if (vecs[i].v0 || vecs[i].v1)
                chk($sformatf("v%0d_rdata", i), 32'(rdata), 32'(vecs[i].rd));
        end

        // Reset pulse while a read of addr 3 is granted but not yet returned.
        @(posedge clk);
        #1;
        idle();
        req0 = 1; addr0 = 4'd3;
        #1;
        chk("flight_gnt0", 32'(gnt0), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("flight_rst_gnt0", 32'(gnt0), 32'd0);
        chk("flight_rst_we", 32'(ram_we), 32'd0);
        idle();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("flight_rvalid0", 32'(rvalid0), 32'd0);
            chk("flight_rst_we_hold", 32'(ram_we), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reinit_we", 32'(ram_we), 32'd1);
        chk("reinit_addr", 32'(ram_addr), 32'd0);
        chk("reinit_done", 32'(init_done), 32'd0);
        chk("reinit_rvalid0", 32'(rvalid0), 32'd0);
        repeat (16) @(posedge clk);
        #1;
        chk("reinit_done_high", 32'(init_done), 32'd1);
        req0 = 1; we0 = 0; addr0 = 4'd3;
        #1;
        chk("post_gnt0", 32'(gnt0), 32'd1);
        @(posedge clk);
        #1;
        idle();
        #1;
        chk("post_rvalid0", 32'(rvalid0), 32'd1);
        chk("post_rdata_cleared", 32'(rdata), 32'd0);
        @(posedge clk);
        #1;
        chk("post_rvalid0_single", 32'(rvalid0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
